// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit saturating counters
module btb_predictor #(
  parameter int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - INDEX_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        br_sel_BTB_o,
  output logic [31:0] predicted_pc_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        flush_i
);
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [INDEX_W-1:0] idx, uidx;
  logic [TAG_W-1:0]   tag, utag;
  logic               hit, uhit, upd_en;
  always_comb begin
    idx            = pc_i[INDEX_W+1:2];
    tag            = pc_i[31:INDEX_W+2];
    uidx           = upd_pc_i[INDEX_W+1:2];
    utag           = upd_pc_i[31:INDEX_W+2];
    hit            = valid_q[idx] && tag_q[idx] == tag;
    uhit           = valid_q[uidx] && tag_q[uidx] == utag;
    upd_en         = !rst_i && !flush_i && upd_valid_i;
    br_sel_BTB_o   = !rst_i && hit && ctr_q[idx][1];
    predicted_pc_o = br_sel_BTB_o ? target_q[idx] : pc_i + 32'd4;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (uhit)
        ctr_q[uidx] <= upd_taken_i ? (ctr_q[uidx] == 2'b11 ? 2'b11 : ctr_q[uidx] + 2'b01)
                                   : (ctr_q[uidx] == 2'b00 ? 2'b00 : ctr_q[uidx] - 2'b01);
      else if (upd_taken_i) begin
        valid_q[uidx] <= 1'b1;
        ctr_q[uidx]   <= 2'b10;
      end
    end
  end
  // Tag rewrite on a taken hit is harmless: the tag already matches.
  always_ff @(posedge clk_i) begin
    if (upd_en && upd_taken_i) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= upd_target_i;
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed table plus randomized run against an array-based reference model
module tb_btb_predictor;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        br_sel_BTB_o;
  logic [31:0] predicted_pc_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        flush_i = 1'b0;
  btb_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .br_sel_BTB_o(br_sel_BTB_o),
    .predicted_pc_o(predicted_pc_o), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .flush_i(flush_i)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic        rs, fl, uv, ut;
    logic [31:0] pc, upc, utgt;
    logic        exp_sel;
    logic [31:0] exp_pc;
  } vec_t;
  int passed = 0, total = 0;
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s #%0d: got %h, expected %h", name, n, act, exp);
  endtask
  function automatic bit model_sel(input logic [31:0] pc, input logic rs);
    int unsigned i = (pc / 4) % 16;
    return !rs && m_valid[i] && m_tag[i] == pc / 64 && m_ctr[i] >= 2;
  endfunction
  task automatic model_update(input vec_t v);
    int unsigned i = (v.upc / 4) % 16;
    bit h = m_valid[i] && m_tag[i] == v.upc / 64;
    if (v.rs) for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
    else if (v.fl) for (int k = 0; k < 16; k++) m_valid[k] = 0;
    else if (v.uv && h) begin
      m_ctr[i] = v.ut ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
      if (v.ut) m_tgt[i] = v.utgt;
    end else if (v.uv && v.ut) begin
      m_valid[i] = 1; m_tag[i] = v.upc / 64; m_tgt[i] = v.utgt; m_ctr[i] = 2;
    end
  endtask
  task automatic step(input vec_t v, input string name, input int n);
    rst_i = v.rs; flush_i = v.fl; upd_valid_i = v.uv; upd_taken_i = v.ut;
    pc_i = v.pc; upd_pc_i = v.upc; upd_target_i = v.utgt;
    #4;
    chk({name, ".sel"}, n, {31'd0, br_sel_BTB_o}, {31'd0, v.exp_sel});
    chk({name, ".pc"}, n, predicted_pc_o, v.exp_pc);
    @(posedge clk_i);
    model_update(v);
    #1;
  endtask
  function automatic vec_t mk(input logic rs, fl, uv, ut, input logic [31:0] pc, upc, utgt,
                              input logic es, input logic [31:0] ep);
    vec_t v;
    v.rs = rs; v.fl = fl; v.uv = uv; v.ut = ut; v.pc = pc; v.upc = upc; v.utgt = utgt;
    v.exp_sel = es; v.exp_pc = ep;
    return v;
  endfunction
  vec_t tbl[$];
  initial begin
    tbl = '{
      mk(1,0,1,1,32'h104,32'h104,32'h80, 0,32'h108),
      mk(0,0,0,0,32'h104,0,0, 0,32'h108),
      mk(0,0,0,0,32'hFFFFFFFC,0,0, 0,32'h0),
      mk(0,0,1,1,32'h104,32'h104,32'h80, 0,32'h108),
      mk(0,0,0,0,32'h104,0,0, 1,32'h80),
      mk(0,0,1,0,32'h104,32'h104,32'h0, 1,32'h80),
      mk(0,0,0,0,32'h104,0,0, 0,32'h108),
      mk(0,0,1,1,32'h104,32'h104,32'h80, 0,32'h108),
      mk(0,0,1,1,32'h104,32'h104,32'h80, 1,32'h80),
      mk(0,0,1,1,32'h104,32'h104,32'h80, 1,32'h80),
      mk(0,0,1,0,32'h104,32'h104,32'h0, 1,32'h80),
      mk(0,0,0,0,32'h104,0,0, 1,32'h80),
      mk(0,0,0,0,32'h144,0,0, 0,32'h148),
      mk(0,0,1,0,32'h104,32'h144,32'h0, 1,32'h80),
      mk(0,0,0,0,32'h104,0,0, 1,32'h80),
      mk(0,0,0,0,32'h144,0,0, 0,32'h148),
      mk(0,0,1,1,32'h144,32'h144,32'h200, 0,32'h148),
      mk(0,0,0,0,32'h144,0,0, 1,32'h200),
      mk(0,0,0,0,32'h104,0,0, 0,32'h108),
      mk(0,0,1,1,32'h308,32'h308,32'h400, 0,32'h30C),
      mk(0,0,0,0,32'h308,0,0, 1,32'h400),
      mk(0,1,1,1,32'h144,32'h304,32'h500, 1,32'h200),
      mk(0,0,0,0,32'h304,0,0, 0,32'h308),
      mk(0,0,0,0,32'h144,0,0, 0,32'h148),
      mk(0,0,0,0,32'h308,0,0, 0,32'h30C),
      mk(0,0,1,1,32'h104,32'h104,32'h80, 0,32'h108),
      mk(0,0,0,0,32'h104,0,0, 1,32'h80),
      mk(1,0,1,1,32'h104,32'h308,32'h400, 0,32'h108),
      mk(0,0,0,0,32'h104,0,0, 0,32'h108),
      mk(0,0,0,0,32'h308,0,0, 0,32'h30C)
    };
    @(posedge clk_i);
    #1;
    foreach (tbl[n]) step(tbl[n], "dir", n);
    step(mk(1,0,0,0,32'h0,0,0, 0,32'h4), "rst", 0);
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v.rs   = ($urandom_range(0, 199) == 0);
      v.fl   = ($urandom_range(0, 59) == 0);
      v.uv   = $urandom_range(0, 1);
      v.ut   = ($urandom_range(0, 9) < 6);
      v.pc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      v.upc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) v.pc = 32'hFFFFFFFC;
      v.utgt = $urandom;
      v.exp_sel = model_sel(v.pc, v.rs);
      v.exp_pc  = v.exp_sel ? m_tgt[(v.pc / 4) % 16] : v.pc + 32'd4;
      step(v, "rnd", n);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-side branch target buffer. It produces the br_sel_BTB and predicted_pc values that the IF/ID pipeline register captures alongside pc and instr.
- Lookup is combinational on the current fetch PC.
- The EX stage trains the table through a single update port once it resolves a branch.
- Direct-mapped. Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.

Parameters:
- ENTRIES, 16, number of table entries; must be a power of two, minimum 2.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pc_i  input  32  current fetch PC.
- br_sel_BTB_o  output  1  1 = redirect fetch to predicted_pc_o.
- predicted_pc_o  output  32  next fetch PC.
- upd_valid_i  input  1  resolved branch/jump update strobe from EX.
- upd_pc_i  input  32  PC of the resolved instruction.
- upd_taken_i  input  1  actual outcome; 1 = taken.
- upd_target_i  input  32  actual target address.
- flush_i  input  1  invalidate all entries, e.g. on fence.i.

Behaviour:
- Address split:
  - index = pc[INDEX_W+1:2].
  - tag = pc[31:INDEX_W+2].
  - pc[1:0] is ignored.
- Lookup (combinational, no storage latency):
  - hit = valid[idx] && tag[idx] == tag(pc_i).
  - br_sel_BTB_o = hit && ctr[idx][1].
  - predicted_pc_o = br_sel_BTB_o ? target[idx] : pc_i + 32'd4. The addition wraps modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
- Update (registered, takes effect at the next rising edge when upd_valid_i = 1):
  - Update hit, taken: ctr = sat_inc(ctr); target = upd_target_i.
  - Update hit, not taken: ctr = sat_dec(ctr); target, tag and valid unchanged.
  - Update miss, taken: allocate the entry, overwriting any aliasing entry. valid = 1, tag = tag(upd_pc_i), target = upd_target_i, ctr = 2'b10 (weakly taken).
  - Update miss, not taken: no change.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - Saturates at 00 and 11.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-old). The new contents are visible from the next cycle.
- Priority, highest first:
  1. rst_i.
  2. flush_i.
  3. update.
- flush_i and upd_valid_i asserted together: all valid bits clear and the update is dropped.
- Reset, synchronous; also applies mid-operation:
  - At the edge with rst_i = 1, every valid bit clears and every ctr is set to 01.
  - Tags and targets need not be reset.
  - While rst_i is high, outputs are forced: br_sel_BTB_o = 0, predicted_pc_o = pc_i + 4.
  - From the first cycle after reset deassertion, every lookup misses until training occurs.
- flush_i clears valid bits only; counters are untouched. Outputs are not forced during the flush cycle.
- No X propagation: outputs are defined for any pc_i after reset.

Test Plan:
(ENTRIES = 16; index = pc[5:2], tag = pc[31:6].)
1. Reset, then pc_i = 0x104 -> br_sel_BTB_o = 0, predicted_pc_o = 0x108. pc_i = 0xFFFFFFFC -> predicted_pc_o = 0x00000000.
2. Training and read-old:
   - Cycle N: upd_valid_i = 1, upd_pc_i = 0x104, upd_taken_i = 1, upd_target_i = 0x80, pc_i = 0x104 -> cycle N outputs br_sel_BTB_o = 0, predicted_pc_o = 0x108 (read-old).
   - Cycle N+1: br_sel_BTB_o = 1, predicted_pc_o = 0x80.
3. Hysteresis:
   - From scenario 2 (ctr = 10), one not-taken update at 0x104 -> ctr = 01. Lookup 0x104 -> br_sel_BTB_o = 0, predicted_pc_o = 0x108; entry remains valid.
   - Then three taken updates -> ctr saturates at 11.
   - Then one not-taken update -> ctr = 10. Lookup 0x104 -> still br_sel_BTB_o = 1, predicted_pc_o = 0x80.
4. Aliasing:
   - With 0x104 trained, lookup 0x144 (same index 1, tag 5) -> miss, predicted_pc_o = 0x148.
   - Not-taken update at 0x144 -> no change; 0x104 still hits.
   - Taken update at 0x144 with target 0x200 -> lookup 0x144 predicts 0x200; lookup 0x104 now misses (0x108).
5. Flush/reset mid-operation:
   - With entries trained, assert flush_i together with a taken update at 0x304 -> the next cycle every lookup, including 0x304, misses.
   - Retrain 0x104, then hold rst_i = 1 for one cycle with a concurrent update -> outputs are forced during reset, all entries miss afterward, and the update is lost.
